// File: rtl/asoc_emu_pkg.sv
// Shared constants for the ASOC burst emulator: pattern codes,
// LFSR seed/taps and FSM state encoding.
package asoc_emu_pkg;

    localparam logic [1:0] PAT_RAMP  = 2'd0;
    localparam logic [1:0] PAT_LFSR  = 2'd1;
    localparam logic [1:0] PAT_CONST = 2'd2;
    localparam logic [1:0] PAT_EVTID = 2'd3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 -> bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/asoc_lfsr16.sv
// 16-bit Fibonacci LFSR, left shift, advances on i_en,
// synchronous reseed to LFSR_SEED.
module asoc_lfsr16
    import asoc_emu_pkg::*;
#(
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             i_reseed,
    input  logic             i_en,
    output logic [OUT_W-1:0] o_data
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (i_reseed) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_en) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_data = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/asoc_burst_emulator.sv
// ASOC-side burst source: on trigger emits N_CH x N_SAMP samples,
// sample-major, on a valid/ready stream, then idles GAP_CYC cycles.
module asoc_burst_emulator
    import asoc_emu_pkg::*;
#(
    parameter int DATA_W  = 12,
    parameter int N_CH    = 8,
    parameter int N_SAMP  = 64,
    parameter int GAP_CYC = 4
) (
    input  logic                      clk_sys,
    input  logic                      rst_sys_n,
    input  logic                      cfg_enable,
    input  logic [1:0]                cfg_pattern,
    input  logic [DATA_W-1:0]         cfg_const,
    input  logic                      trig_in,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(N_CH)-1:0]   out_ch,
    output logic [$clog2(N_SAMP)-1:0] out_samp,
    output logic                      out_sof,
    output logic                      out_eof,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic [15:0]               evt_cnt,
    output logic [7:0]                drop_cnt
);

    localparam int CW = $clog2(N_CH);
    localparam int SW = $clog2(N_SAMP);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [CW-1:0] C_LAST = CW'(N_CH - 1);
    localparam logic [SW-1:0] S_LAST = SW'(N_SAMP - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC - 1);

    logic [1:0]        r_state;
    logic [1:0]        r_pat;
    logic [DATA_W-1:0] r_const;
    logic [DATA_W-1:0] r_evt_id;
    logic [15:0]       r_evt_cnt;
    logic [7:0]        r_drop;
    logic              r_valid;
    logic              r_busy;
    logic [CW-1:0]     r_ch;
    logic [SW-1:0]     r_samp;
    logic [GW-1:0]     r_gap;

    logic              w_hs;
    logic              w_last;
    logic              w_accept;
    logic              w_first;
    logic [DATA_W-1:0] w_lfsr;
    logic [DATA_W-1:0] w_ramp;
    logic [DATA_W-1:0] w_data;

    assign w_hs     = r_valid && out_ready;
    assign w_first  = (r_ch == '0) && (r_samp == '0);
    assign w_last   = (r_ch == C_LAST) && (r_samp == S_LAST);
    assign w_accept = (r_state == IDLE) && trig_in && cfg_enable;

    // LFSR steps on every accepted beat whatever the pattern
    asoc_lfsr16 #(
        .OUT_W(DATA_W)
    ) u_lfsr (
        .clk     (clk_sys),
        .i_reseed(!rst_sys_n),
        .i_en    (w_hs),
        .o_data  (w_lfsr)
    );

    always_comb begin
        w_ramp = DATA_W'((32'(r_ch) << 8) | 32'(r_samp));
        w_data = '0;
        unique case (r_pat)
            PAT_RAMP:  w_data = w_ramp;
            PAT_LFSR:  w_data = w_lfsr;
            PAT_CONST: w_data = r_const;
            PAT_EVTID: w_data = r_evt_id;
            default:   w_data = '0;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            r_state   <= IDLE;
            r_pat     <= PAT_RAMP;
            r_const   <= '0;
            r_evt_id  <= '0;
            r_evt_cnt <= '0;
            r_drop    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_ch      <= '0;
            r_samp    <= '0;
            r_gap     <= '0;
        end else begin
            if (trig_in && (r_state != IDLE) && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_pat     <= cfg_pattern;
                        r_const   <= cfg_const;
                        r_evt_id  <= r_evt_cnt[DATA_W-1:0];
                        r_evt_cnt <= r_evt_cnt + 16'd1;
                        r_ch      <= '0;
                        r_samp    <= '0;
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= SEND;
                    end
                end
                SEND: begin
                    if (w_hs) begin
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_ch    <= '0;
                            r_samp  <= '0;
                            r_gap   <= '0;
                            if (GAP_CYC == 0) begin
                                r_busy  <= 1'b0;
                                r_state <= IDLE;
                            end else begin
                                r_state <= GAP;
                            end
                        end else if (r_ch == C_LAST) begin
                            r_ch   <= '0;
                            r_samp <= r_samp + SW'(1);
                        end else begin
                            r_ch <= r_ch + CW'(1);
                        end
                    end
                end
                GAP: begin
                    if (r_gap == G_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_data  = r_valid ? w_data : '0;
    assign out_ch    = r_ch;
    assign out_samp  = r_samp;
    assign out_sof   = r_valid && w_first;
    assign out_eof   = r_valid && w_last;
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign evt_cnt   = r_evt_cnt;
    assign drop_cnt  = r_drop;

endmodule

// File: doc/asoc_burst_emulator.md
Name: asoc_burst_emulator

Overview:
- Synthesizable ASOC-side data source that plays the transmitter role of the ASOC readout path.
- On a trigger it emits one burst of waveform samples, N_CH channels x N_SAMP samples, on a valid/ready stream.
- The stream is shaped like what the ASOC capture/buffering logic consumes.
- Used in fpga/sim benches and for on-board loopback bring-up of the capture and framing path without a real ASOC.

Parameters:
- DATA_W, 12, sample width in bits (ASOC ADC resolution); legal range 8..16.
- N_CH, 8, channels per burst; power of two, 2..16.
- N_SAMP, 64, samples per channel per burst; power of two, 4..256.
- GAP_CYC, 4, idle cycles enforced after a burst before the next trigger is accepted; 0 is legal.

Ports:
- clk_sys  in  1  system clock; the only clock.
- rst_sys_n  in  1  synchronous, active-low reset.
- cfg_enable  in  1  allows trigger acceptance.
- cfg_pattern  in  2  0=ramp, 1=LFSR, 2=constant, 3=event-ID.
- cfg_const  in  DATA_W  value for pattern 2.
- trig_in  in  1  trigger; level sampled each cycle.
- out_data  out  DATA_W  sample.
- out_ch  out  log2(N_CH)  channel index of the current beat.
- out_samp  out  log2(N_SAMP)  sample index of the current beat.
- out_sof  out  1  first beat of a burst.
- out_eof  out  1  last beat of a burst.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts the beat.
- busy  out  1  high in SEND or GAP.
- evt_cnt  out  16  accepted-trigger count; wraps.
- drop_cnt  out  8  triggers ignored while busy; saturates at 255.

Behaviour:
- Reset values: all outputs 0; state IDLE; LFSR = 16'hACE1.
- State IDLE:
  - If trig_in && cfg_enable at edge t: latch cfg_pattern, cfg_const and evt_id = evt_cnt.
  - Increment evt_cnt, zero the beat indices, go to SEND.
  - out_valid=1 from cycle t+1 (1-cycle latency), with out_sof=1.
  - trig_in with cfg_enable=0 is ignored and not counted.
- State SEND:
  - Beat order is sample-major: for s in 0..N_SAMP-1, for c in 0..N_CH-1.
  - Total N_CH*N_SAMP beats.
  - Indices advance only on handshake (out_valid && out_ready).
  - While out_valid && !out_ready, out_data, out_ch, out_samp, out_sof and out_eof hold stable.
  - out_sof is high only on beat (s=0, c=0); out_eof is high only on beat (s=N_SAMP-1, c=N_CH-1).
  - On the eof handshake: out_valid drops the next cycle; go to GAP, or to IDLE if GAP_CYC=0.
  - Back-to-back handshakes give one beat per cycle with no bubbles.
- State GAP: counts GAP_CYC cycles, then goes to IDLE. The earliest next trigger acceptance is in the first IDLE cycle.
- Dropped triggers: trig_in=1 while busy (SEND or GAP) increments drop_cnt by 1 per cycle asserted, saturating at 255.
- Patterns, computed for the current beat:
  - Ramp: data = ((c << 8) | s) truncated to DATA_W.
  - LFSR: data = lfsr[DATA_W-1:0]. The LFSR is Fibonacci x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0. It advances only on handshakes and persists across bursts; only reset reseeds it.
  - Constant: data = latched cfg_const.
  - Event-ID: data = evt_id[DATA_W-1:0] on every beat.
- Mid-burst changes: cfg changes or cfg_enable=0 during SEND do not affect the burst in progress, which completes.
- Reset mid-burst: rst_sys_n=0 at any edge returns every output to its reset value at that edge. The burst is abandoned and is not resumed.
- Wrap-around: evt_cnt wraps 16'hFFFF -> 0.
- busy is registered: high from cycle t+1 through the last GAP cycle.

Decomposition:
- Package asoc_emu_pkg holds:
  - pattern encoding constants (PAT_RAMP, PAT_LFSR, PAT_CONST, PAT_EVTID);
  - LFSR_SEED=16'hACE1 and the tap mask;
  - state encoding (IDLE, SEND, GAP).
- Sub-module asoc_lfsr16: the 16-bit LFSR with enable and synchronous reseed.

Test Plan:
- Defaults, pattern 0, out_ready=1, single trigger:
  - beat 0 has out_data=12'h000, sof=1, out_valid at t+1;
  - beat 1 has c=1, data=12'h100;
  - beat 8 has s=1, c=0, data=12'h001;
  - beat 511 has data=12'h73F, eof=1;
  - 512 beats over 512 consecutive cycles; busy falls 4 cycles after eof.
- Random out_ready at 30% duty, pattern 1:
  - beats stay stable while stalled;
  - sequence matches the reference LFSR from seed 16'hACE1;
  - a second burst continues the sequence without reseeding.
- trig_in held high for 600 cycles, out_ready=1, cfg_enable=1:
  - a new burst is accepted every 512+4+1 cycles;
  - drop_cnt saturates at 255.
- Pattern 3 after 3 prior triggers: every beat has data=12'h003; evt_cnt=4.
- Reset asserted at beat 100 mid-stall: next cycle out_valid=0, evt_cnt=0, drop_cnt=0; the next burst restarts at sof with the LFSR reseeded.
- Mid-burst changes: cfg_pattern changed 0->2 and cfg_enable=0 during SEND; the burst completes as a ramp, and a subsequent trigger is ignored and not counted.
